// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared encodings for the iterative AES core: cipher direction, one-hot key
// length, datapath mux selects, the round sequencer state enum and the bundle
// of registered datapath controls.
//   nr_rounds()   : key length -> round count Nr (non-one-hot falls back to 10)
//   ctrl_decode() : sequencer state -> datapath control bundle
// -----------------------------------------------------------------------------
package aes_pkg;

   // Cipher direction
   localparam logic AES_ENC = 1'b0;
   localparam logic AES_DEC = 1'b1;

   // One-hot key length
   localparam logic [2:0] AES_128 = 3'b001;
   localparam logic [2:0] AES_192 = 3'b010;
   localparam logic [2:0] AES_256 = 3'b100;

   // State register input mux; 0 is the idle value while state_we is low
   localparam logic [1:0] STATE_NONE  = 2'd0;
   localparam logic [1:0] STATE_INIT  = 2'd1;
   localparam logic [1:0] STATE_ROUND = 2'd2;
   localparam logic [1:0] STATE_CLEAR = 2'd3;

   // Add-round-key operand mux
   localparam logic [1:0] ADD_RK_NONE  = 2'd0;
   localparam logic [1:0] ADD_RK_INIT  = 2'd1;
   localparam logic [1:0] ADD_RK_ROUND = 2'd2;
   localparam logic [1:0] ADD_RK_FINAL = 2'd3;

   // Key expander full-key mux; all four codes are used
   localparam logic [1:0] KEY_FULL_ENC_INIT = 2'd0;
   localparam logic [1:0] KEY_FULL_DEC_INIT = 2'd1;
   localparam logic [1:0] KEY_FULL_ROUND    = 2'd2;
   localparam logic [1:0] KEY_FULL_CLEAR    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4,
      ST_CLEAR = 3'd5
   } round_state_e;

   typedef struct packed {
      logic [1:0] state_sel;
      logic       state_we;
      logic [1:0] add_rk_sel;
      logic       key_step;
      logic [1:0] key_full_sel;
      logic       mix_bypass;
      logic       out_valid;
   } ctrl_t;

   function automatic logic [3:0] nr_rounds(input logic [2:0] key_len);
      case (key_len)
         AES_192: return 4'd12;
         AES_256: return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic ctrl_t ctrl_decode(input round_state_e st, input logic mode);
      ctrl_t c;
      c = '0;
      case (st)
         ST_INIT: begin
            c.state_sel    = STATE_INIT;
            c.add_rk_sel   = ADD_RK_INIT;
            c.state_we     = 1'b1;
            c.key_full_sel = (mode == AES_DEC) ? KEY_FULL_DEC_INIT : KEY_FULL_ENC_INIT;
         end
         ST_ROUND, ST_FINAL: begin
            c.state_sel    = STATE_ROUND;
            c.add_rk_sel   = (st == ST_FINAL) ? ADD_RK_FINAL : ADD_RK_ROUND;
            c.state_we     = 1'b1;
            c.key_step     = 1'b1;
            c.key_full_sel = KEY_FULL_ROUND;
            c.mix_bypass   = (st == ST_FINAL);
         end
         ST_DONE: begin
            c.out_valid    = 1'b1;
         end
         ST_CLEAR: begin
            c.state_sel    = STATE_CLEAR;
            c.key_full_sel = KEY_FULL_CLEAR;
            c.state_we     = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl_if
// Request/response handshake plus datapath control bundle of the AES round
// sequencer.
//   master : the side issuing block requests and consuming results
//   slave  : the round sequencer itself
// -----------------------------------------------------------------------------
interface aes_round_ctrl_if;

   logic       in_valid_i;
   logic       in_ready_o;
   logic       mode_i;
   logic [2:0] key_len_i;
   logic       clear_i;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [1:0] state_sel_o;
   logic       state_we_o;
   logic [1:0] add_rk_sel_o;
   logic       key_step_o;
   logic [1:0] key_full_sel_o;
   logic [3:0] round_o;
   logic       mode_o;
   logic       mix_bypass_o;
   logic       err_o;

   modport master (
      output in_valid_i, mode_i, key_len_i, clear_i, out_ready_i,
      input  in_ready_o, out_valid_o, state_sel_o, state_we_o, add_rk_sel_o,
             key_step_o, key_full_sel_o, round_o, mode_o, mix_bypass_o, err_o
   );

   modport slave (
      input  in_valid_i, mode_i, key_len_i, clear_i, out_ready_i,
      output in_ready_o, out_valid_o, state_sel_o, state_we_o, add_rk_sel_o,
             key_step_o, key_full_sel_o, round_o, mode_o, mix_bypass_o, err_o
   );

endinterface

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Round sequencer for the iterative AES core. Accepts one block per handshake,
// then walks INIT -> ROUND x(Nr-1) -> FINAL -> DONE, driving the state
// register, add-round-key, key expander and ShiftRows/MixColumns controls.
// Ports:
//   clk_i  : core clock
//   rst_i  : asynchronous reset, active-high
//   bus    : aes_round_ctrl_if.slave (request in, datapath controls out)
// All outputs come from registers, except in_ready_o which also gates on
// clear_i so an abort can never coincide with an accept.
// -----------------------------------------------------------------------------
module aes_round_ctrl
   import aes_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   aes_round_ctrl_if.slave  bus
);

   round_state_e r_state;
   round_state_e w_state_nxt;
   logic [3:0]   r_round;
   logic [3:0]   r_nr;
   logic         r_mode;
   logic         r_err;
   ctrl_t        r_ctrl;

   logic         w_accept;
   logic         w_mode_nxt;
   logic [3:0]   w_round_nxt;

   assign w_accept   = (r_state == ST_IDLE) && bus.in_valid_i && !bus.clear_i;
   assign w_mode_nxt = w_accept ? bus.mode_i : r_mode;

   // NOTE: the default assignment first guarantees every path writes
   // w_state_nxt, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.clear_i && (r_state != ST_CLEAR)) begin
         // Abort wins everywhere; in DONE the result handshake still counts.
         w_state_nxt = ST_CLEAR;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_INIT;
            ST_INIT:  w_state_nxt = ST_ROUND;
            ST_ROUND: if (r_round == (r_nr - 4'd1)) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = ST_DONE;
            ST_DONE:  if (bus.out_ready_i) w_state_nxt = ST_IDLE;
            ST_CLEAR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Round index follows the state entered next cycle, so round_o lines up
   // with the registered controls: 0 in INIT, 1..Nr-1 in ROUND, Nr in FINAL.
   always_comb begin
      w_round_nxt = r_round;
      if (w_accept) begin
         w_round_nxt = 4'd0;
      end else if ((w_state_nxt == ST_ROUND) || (w_state_nxt == ST_FINAL)) begin
         w_round_nxt = r_round + 4'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_round <= 4'd0;
         r_nr    <= 4'd10;
         r_mode  <= AES_ENC;
         r_err   <= 1'b0;
         r_ctrl  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_mode  <= w_mode_nxt;
         if (w_accept) begin
            r_nr <= nr_rounds(bus.key_len_i);
         end
         // err_o is visible during INIT, one cycle after the offending accept.
         r_err  <= w_accept && !$onehot(bus.key_len_i);
         r_ctrl <= ctrl_decode(w_state_nxt, w_mode_nxt);
      end
   end

   assign bus.in_ready_o     = (r_state == ST_IDLE) && !bus.clear_i;
   assign bus.out_valid_o    = r_ctrl.out_valid;
   assign bus.state_sel_o    = r_ctrl.state_sel;
   assign bus.state_we_o     = r_ctrl.state_we;
   assign bus.add_rk_sel_o   = r_ctrl.add_rk_sel;
   assign bus.key_step_o     = r_ctrl.key_step;
   assign bus.key_full_sel_o = r_ctrl.key_full_sel;
   assign bus.mix_bypass_o   = r_ctrl.mix_bypass;
   assign bus.round_o        = r_round;
   assign bus.mode_o         = r_mode;
   assign bus.err_o          = r_err;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES cipher core. It accepts one block request per handshake and counts rounds according to key length: 10 rounds for AES_128, 12 for AES_192, 14 for AES_256. Each cycle it drives the select and enable controls for the state register, the add-round-key mux, the key expander and the ShiftRows/MixColumns stage. It sits between the top-level AES control FSM and the combinational round datapath, and it owns no data.

## Interface
- Parameters: none. Key-length, mode and mux encodings come from the shared package.
- Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-high
- in_valid_i  in  1  block request valid
- in_ready_o  out  1  request accepted when high with in_valid_i
- mode_i  in  1  AES_ENC=0, AES_DEC=1; sampled at accept
- key_len_i  in  3  one-hot AES_128=001, AES_192=010, AES_256=100; sampled at accept
- clear_i  in  1  abort and clear request
- out_valid_o  out  1  result in state register valid
- out_ready_i  in  1  consumer takes result
- state_sel_o  out  2  STATE_INIT/ROUND/CLEAR
- state_we_o  out  1  state register write enable
- add_rk_sel_o  out  2  ADD_RK_INIT/ROUND/FINAL
- key_step_o  out  1  advance key expander one round
- key_full_sel_o  out  2  KEY_FULL_ENC_INIT/DEC_INIT/ROUND/CLEAR
- round_o  out  4  current round index 0..14
- mode_o  out  1  latched mode, drives the ShiftRows/MixColumns direction
- mix_bypass_o  out  1  skip MixColumns (final round)
- err_o  out  1  one-cycle pulse: key_len_i was not one-hot at accept

## Operation
- The FSM has five states: IDLE, INIT, ROUND, FINAL, DONE. A sixth state, CLEAR, handles aborts.
- Nr is the round count: 10, 12 or 14, latched at accept. A key_len_i that is not one-hot is treated as AES_128, and err_o pulses in the INIT cycle.
- IDLE:
  - in_ready_o = !clear_i.
  - On accept, latch mode and Nr and go to INIT.
- INIT (one cycle):
  - state_sel=STATE_INIT, add_rk_sel=ADD_RK_INIT, state_we=1, round=0.
  - key_full_sel=KEY_FULL_ENC_INIT for enc, KEY_FULL_DEC_INIT for dec.
- ROUND (Nr-1 cycles, round=1..Nr-1):
  - state_sel=STATE_ROUND, add_rk_sel=ADD_RK_ROUND, state_we=1.
  - key_step=1, key_full_sel=KEY_FULL_ROUND.
- FINAL (one cycle, round=Nr):
  - Same controls as ROUND, except add_rk_sel=ADD_RK_FINAL and mix_bypass=1.
- DONE:
  - out_valid=1 and state_we=0, held until out_ready_i. Then go to IDLE.
- CLEAR (one cycle):
  - state_sel=STATE_CLEAR, key_full_sel=KEY_FULL_CLEAR, state_we=1. Then go to IDLE.
- clear_i high in any state other than CLEAR: the next state is CLEAR.
  - clear_i beats a simultaneous accept in IDLE: the input is not taken.
  - clear_i in DONE together with out_ready_i: the transfer completes, then the FSM goes to CLEAR.
- Default outputs, in any state not listed: selects=0, enables=0, mix_bypass=0.
- round_o: a 4-bit counter, cleared on accept, incremented on each ROUND/FINAL entry. It never exceeds 14.
- mode_i and key_len_i changing after accept have no effect until the next accept.

## Timing
- Reset values:
  - FSM state = IDLE.
  - in_ready_o=1; every other output = 0. round_o=0, mode_o=0.
  - Latched Nr = 10.
- rst_i asserted mid-operation returns the FSM to IDLE immediately. No CLEAR cycle is issued.
- Cycle numbering: accept at cycle 0, INIT at cycle 1.
  - ROUND occupies cycles 2..Nr.
  - FINAL is cycle Nr+1.
  - out_valid_o first rises in cycle Nr+2: 12, 14 or 16.
- Back-to-back throughput: one block per Nr+3 cycles when out_ready_i is held high. in_ready_o rises the cycle after the DONE handshake.
- All outputs are decoded from registered state, with one exception: in_ready_o also depends combinationally on clear_i.

## Structure
- aes_pkg holds:
  - AES_ENC/AES_DEC.
  - AES_128/192/256.
  - STATE_*, ADD_RK_*, KEY_FULL_*.
  - The FSM state enum.
- The package also holds a nr_rounds function mapping key_len to Nr.
- No sub-module: the block is one FSM plus the round counter.

## Test plan
- AES_128 enc:
  - Stimulus: accept at cycle 0, out_ready held high.
  - Required: round_o steps 0,1..10. mix_bypass is high only at cycle 11. out_valid at cycle 12. in_ready high again at cycle 13.
- AES_256 dec:
  - Required: key_full_sel=DEC_INIT at cycle 1, mode_o=1 throughout, FINAL at cycle 15 with round=14, out_valid at cycle 16.
- Backpressure:
  - Stimulus: AES_192, out_ready low for 5 cycles after DONE.
  - Required: out_valid is held, state_we=0, in_ready=0. The handshake then returns the FSM to IDLE.
- Abort:
  - Stimulus: clear_i at round 4 of AES_128.
  - Required: the next cycle shows CLEAR (state_sel=STATE_CLEAR, key_full_sel=KEY_FULL_CLEAR, state_we=1), then IDLE. out_valid never rises.
- Conflicts:
  - clear_i and in_valid together in IDLE: no accept.
  - Bad key_len 3'b011: runs as 10 rounds, err_o pulses at cycle 1.
- Reset at round 7: all outputs return to reset values asynchronously, and a new request is accepted after release.
